// File: rtl/ucode_mul_sequencer_if.sv
// Handshake bundle for ucode_mul_sequencer: macro-op start side (from ID) and
// micro-instruction output side (towards the pipeline instruction mux).
interface ucode_mul_sequencer_if #(
   parameter int unsigned IMM_W = 16
);
   logic             start_valid;
   logic             start_ready;
   logic [1:0]       start_mode;
   logic [3:0]       dest_reg;
   logic [3:0]       source_reg;
   logic [IMM_W-1:0] immediate;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      output_instruction;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start_valid, start_mode, dest_reg, source_reg, immediate, out_ready,
      input  start_ready, out_valid, output_instruction, busy, done, err
   );

   modport slave (
      input  start_valid, start_mode, dest_reg, source_reg, immediate, out_ready,
      output start_ready, out_valid, output_instruction, busy, done, err
   );
endinterface

// File: rtl/ucode_mul_sequencer.sv
// Expands one MUL/MAC/MSU-by-immediate macro-op into a stream of ADD/SUB micro-ops.
// Scratch-register alias handling is compiled in when UCODE_ALIAS_EN is defined.
module ucode_mul_sequencer #(
   parameter int unsigned IMM_W       = 16,
   parameter logic [3:0]  SCRATCH_REG = 4'd15,
   parameter logic [6:0]  ADD_OPC     = 7'b0110001,
   parameter logic [6:0]  SUB_OPC     = 7'b0110010,
   parameter logic [31:0] NOP_WORD    = {5'b11001, 27'b0}
) (
   input logic                  clk,
   input logic                  rst,
   ucode_mul_sequencer_if.slave bus
);
   localparam logic [1:0]       MODE_MUL = 2'b00;
   localparam logic [1:0]       MODE_MSU = 2'b10;
   localparam logic [1:0]       MODE_ILL = 2'b11;
   localparam logic [IMM_W-1:0] CNT_ZERO = {IMM_W{1'b0}};
   localparam logic [IMM_W-1:0] CNT_ONE  = {{(IMM_W-1){1'b0}}, 1'b1};
`ifdef UCODE_ALIAS_EN
   localparam logic ALIAS_EN = 1'b1;
`else
   localparam logic ALIAS_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
`ifdef UCODE_ALIAS_EN
      S_ACLR = 3'd1,
      S_ACPY = 3'd2,
`endif
      S_CLR  = 3'd3,
      S_LOOP = 3'd4,
      S_DONE = 3'd5
   } state_t;

   function automatic logic [31:0] make_insn(input logic [6:0] opc, input logic [3:0] rd,
                                             input logic [3:0] rs1, input logic [3:0] rs2);
      return {opc, rd, rs1, rs2, 13'd0};
   endfunction

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [3:0]       rd_q, rd_d;
   logic [3:0]       rs_q, rs_d;
   logic [IMM_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             alias_q, alias_d;

   logic             accept_s, illegal_s, alias_take_s, hs_s;
   logic [3:0]       es_s;
   logic             out_valid_s, busy_s, start_ready_s, done_s, err_s;
   logic [31:0]      insn_s;

   assign accept_s     = bus.start_valid && (state_q == S_IDLE);
   assign illegal_s    = (bus.start_mode == MODE_ILL) ||
                         (ALIAS_EN && (bus.dest_reg == SCRATCH_REG) && (bus.source_reg == SCRATCH_REG));
   assign alias_take_s = ALIAS_EN && (bus.dest_reg == bus.source_reg) && (bus.immediate != CNT_ZERO);
   assign hs_s         = out_valid_s && bus.out_ready;
   assign es_s         = alias_q ? SCRATCH_REG : rs_q;

   // State and operand registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         mode_q  <= 2'b00;
         rd_q    <= 4'd0;
         rs_q    <= 4'd0;
         cnt_q   <= CNT_ZERO;
         err_q   <= 1'b0;
         alias_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rd_q    <= rd_d;
         rs_q    <= rs_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         alias_q <= alias_d;
      end
   end

   // Next-state: every emitting state advances only on the output handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!accept_s)                      state_d = S_IDLE;
            else if (illegal_s)                 state_d = S_DONE;
`ifdef UCODE_ALIAS_EN
            else if (alias_take_s)              state_d = S_ACLR;
`endif
            else if (bus.start_mode == MODE_MUL) state_d = S_CLR;
            else if (bus.immediate == CNT_ZERO)  state_d = S_DONE;
            else                                 state_d = S_LOOP;
         end
`ifdef UCODE_ALIAS_EN
         S_ACLR: begin
            if (hs_s) state_d = S_ACPY;
            else      state_d = S_ACLR;
         end
         S_ACPY: begin
            if (!hs_s)                   state_d = S_ACPY;
            else if (mode_q == MODE_MUL) state_d = S_CLR;
            else                         state_d = S_LOOP;
         end
`endif
         S_CLR: begin
            if (!hs_s)                  state_d = S_CLR;
            else if (cnt_q == CNT_ZERO) state_d = S_DONE;
            else                        state_d = S_LOOP;
         end
         S_LOOP: begin
            if (hs_s && (cnt_q == CNT_ONE)) state_d = S_DONE;
            else                            state_d = S_LOOP;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand latch on accept; LOOP counts down once per accepted micro-op
   always_comb begin
      mode_d  = mode_q;
      rd_d    = rd_q;
      rs_d    = rs_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      alias_d = alias_q;
      if (accept_s) begin
         mode_d  = bus.start_mode;
         rd_d    = bus.dest_reg;
         rs_d    = bus.source_reg;
         cnt_d   = bus.immediate;
         err_d   = illegal_s;
         alias_d = alias_take_s;
      end else if ((state_q == S_LOOP) && hs_s) begin
         cnt_d = cnt_q - CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Moore outputs decoded from the registered state
   always_comb begin
      out_valid_s   = 1'b0;
      insn_s        = NOP_WORD;
      busy_s        = 1'b1;
      start_ready_s = 1'b0;
      done_s        = 1'b0;
      err_s         = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy_s        = 1'b0;
            start_ready_s = 1'b1;
         end
`ifdef UCODE_ALIAS_EN
         S_ACLR: begin
            out_valid_s = 1'b1;
            insn_s      = make_insn(SUB_OPC, SCRATCH_REG, SCRATCH_REG, SCRATCH_REG);
         end
         S_ACPY: begin
            out_valid_s = 1'b1;
            insn_s      = make_insn(ADD_OPC, SCRATCH_REG, SCRATCH_REG, rs_q);
         end
`endif
         S_CLR: begin
            out_valid_s = 1'b1;
            insn_s      = make_insn(SUB_OPC, rd_q, rd_q, rd_q);
         end
         S_LOOP: begin
            out_valid_s = 1'b1;
            insn_s      = make_insn((mode_q == MODE_MSU) ? SUB_OPC : ADD_OPC, rd_q, rd_q, es_s);
         end
         S_DONE: begin
            done_s = 1'b1;
            err_s  = err_q;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   assign bus.start_ready        = start_ready_s;
   assign bus.out_valid          = out_valid_s;
   assign bus.output_instruction = insn_s;
   assign bus.busy               = busy_s;
   assign bus.done               = done_s;
   assign bus.err                = err_s;
endmodule

// File: tb/tb_ucode_mul_sequencer.sv
// Scoreboard bench for ucode_mul_sequencer: an IMM_W=16 instance for the main
// sequences and an IMM_W=4 instance for the full-range immediate.
module tb_ucode_mul_sequencer;
   localparam logic [6:0]  ADD = 7'b0110001;
   localparam logic [6:0]  SUB = 7'b0110010;
   localparam logic [31:0] NOP = 32'hC800_0000;
`ifdef UCODE_ALIAS_EN
   localparam bit ALIAS_EN = 1'b1;
`else
   localparam bit ALIAS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ucode_mul_sequencer_if #(.IMM_W(16)) ifc ();
   ucode_mul_sequencer_if #(.IMM_W(4))  ifc4 ();

   ucode_mul_sequencer #(.IMM_W(16)) dut  (.clk(clk), .rst(rst), .bus(ifc.slave));
   ucode_mul_sequencer #(.IMM_W(4))  dut4 (.clk(clk), .rst(rst), .bus(ifc4.slave));

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_q[$];
   logic        exp_err;
   int          exp_n;
   int          busy_cnt  = 0;
   int          busy_base = 0;
   logic        done_f, err_f, valid_f, sr_f, busy_f;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] insn(input logic [6:0] opc, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
      return {opc, a, b, c, 13'd0};
   endfunction

   // Expected micro-op list straight from the sequencing rules
   task automatic build_expected(input logic [1:0] mode, input logic [3:0] rd,
                                 input logic [3:0] rs, input int imm);
      logic [3:0] es;
      bit         use_sc;
      exp_q.delete();
      exp_err = 1'b0;
      use_sc  = ALIAS_EN && (rd == rs) && (imm != 0);
      es      = use_sc ? 4'd15 : rs;
      if ((mode == 2'b11) || (ALIAS_EN && (rd == 4'd15) && (rs == 4'd15))) begin
         exp_err = 1'b1;
      end else begin
         if (use_sc) begin
            exp_q.push_back(insn(SUB, 4'd15, 4'd15, 4'd15));
            exp_q.push_back(insn(ADD, 4'd15, 4'd15, rs));
         end
         if (mode == 2'b00) exp_q.push_back(insn(SUB, rd, rd, rd));
         for (int i = 0; i < imm; i++)
            exp_q.push_back(insn((mode == 2'b10) ? SUB : ADD, rd, rd, es));
      end
      exp_n = exp_q.size();
   endtask

   // One clock: sample at negedge, score the output word, return at posedge+1
   task automatic step();
      @(negedge clk);
      done_f  = ifc.done;
      err_f   = ifc.err;
      valid_f = ifc.out_valid;
      sr_f    = ifc.start_ready;
      busy_f  = ifc.busy;
      if (ifc.busy) busy_cnt++;
      if (!ifc.out_valid)        check_val("idle_word", ifc.output_instruction, NOP);
      else if (exp_q.size() == 0) check_val("unexpected_insn", ifc.output_instruction, NOP);
      else if (ifc.out_ready)    check_val("insn", ifc.output_instruction, exp_q.pop_front());
      else                       check_val("held_insn", ifc.output_instruction, exp_q[0]);
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input logic [1:0] mode, input logic [3:0] rd,
                            input logic [3:0] rs, input int imm);
      build_expected(mode, rd, rs, imm);
      ifc.start_valid = 1'b1;
      ifc.start_mode  = mode;
      ifc.dest_reg    = rd;
      ifc.source_reg  = rs;
      ifc.immediate   = 16'(imm);
      @(negedge clk);
      check_val("start_ready", 32'(ifc.start_ready), 32'd1);
      @(posedge clk);
      #1;
      busy_base = busy_cnt;
      // keep offering junk while busy; it must be ignored
      ifc.start_mode = 2'($urandom);
      ifc.dest_reg   = 4'($urandom);
      ifc.source_reg = 4'($urandom);
      ifc.immediate  = 16'($urandom);
   endtask

   task automatic wait_done(input int stalls);
      int n   = 0;
      bit seen = 1'b0;
      int lat = exp_n + 1 + stalls;
      while (!seen && (n < 400)) begin
         step();
         n++;
         if (n <= stalls) check_val("stall_valid", 32'(valid_f), 32'd1);
         if (n == stalls) ifc.out_ready = 1'b1;
         if (done_f) seen = 1'b1;
      end
      ifc.start_valid = 1'b0;
      check_val("done_seen", 32'(seen), 32'd1);
      check_val("done_cycle", 32'(n), 32'(lat));
      check_val("err", 32'(err_f), 32'(exp_err));
      check_val("busy_cycles", 32'(busy_cnt - busy_base), 32'(lat));
      check_val("drained", 32'(exp_q.size()), 32'd0);
      step();
      check_val("done_pulse", 32'(done_f), 32'd0);
      check_val("idle_busy", 32'(busy_f), 32'd0);
      check_val("idle_ready", 32'(sr_f), 32'd1);
   endtask

   initial begin
      int adds, subs, others;
      bit seen4;
      ifc.start_valid  = 1'b0;
      ifc.start_mode   = 2'b00;
      ifc.dest_reg     = 4'd0;
      ifc.source_reg   = 4'd0;
      ifc.immediate    = 16'd0;
      ifc.out_ready    = 1'b0;
      ifc4.start_valid = 1'b0;
      ifc4.start_mode  = 2'b00;
      ifc4.dest_reg    = 4'd0;
      ifc4.source_reg  = 4'd0;
      ifc4.immediate   = 4'd0;
      ifc4.out_ready   = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check_val("rst_busy", 32'(ifc.busy), 32'd0);
      check_val("rst_done", 32'(ifc.done), 32'd0);
      check_val("rst_err", 32'(ifc.err), 32'd0);
      check_val("rst_word", ifc.output_instruction, NOP);
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_start_ready", 32'(ifc.start_ready), 32'd1);
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b1;

      start_req(2'b00, 4'd1, 4'd0, 3);   wait_done(0);
      start_req(2'b00, 4'd6, 4'd2, 0);   wait_done(0);
      start_req(2'b01, 4'd3, 4'd4, 0);   wait_done(0);
      start_req(2'b11, 4'd2, 4'd9, 5);   wait_done(0);
      ifc.out_ready = 1'b0;
      start_req(2'b10, 4'd2, 4'd3, 2);   wait_done(3);
      start_req(2'b01, 4'd7, 4'd8, 4);   wait_done(0);
      start_req(2'b00, 4'd5, 4'd5, 2);   wait_done(0);
      start_req(2'b00, 4'd15, 4'd15, 2); wait_done(0);
      start_req(2'b10, 4'd9, 4'd9, 3);   wait_done(0);

      // reset in the middle of a long MAC
      start_req(2'b01, 4'd4, 4'd6, 100);
      repeat (10) step();
      rst = 1'b0;
      ifc.start_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      check_val("mid_rst_valid", 32'(ifc.out_valid), 32'd0);
      check_val("mid_rst_busy", 32'(ifc.busy), 32'd0);
      check_val("mid_rst_ready", 32'(ifc.start_ready), 32'd1);
      check_val("mid_rst_word", ifc.output_instruction, NOP);
      start_req(2'b00, 4'd3, 4'd9, 1);   wait_done(0);

      // full-range immediate on the narrow instance
      ifc4.start_mode  = 2'b00;
      ifc4.dest_reg    = 4'd7;
      ifc4.source_reg  = 4'd8;
      ifc4.immediate   = 4'd15;
      ifc4.start_valid = 1'b1;
      @(posedge clk);
      #1;
      ifc4.start_valid = 1'b0;
      adds = 0; subs = 0; others = 0; seen4 = 1'b0;
      for (int i = 0; (i < 40) && !seen4; i++) begin
         @(negedge clk);
         if (ifc4.out_valid) begin
            if (ifc4.output_instruction == insn(ADD, 4'd7, 4'd7, 4'd8))      adds++;
            else if (ifc4.output_instruction == insn(SUB, 4'd7, 4'd7, 4'd7)) subs++;
            else                                                             others++;
         end
         if (ifc4.done) seen4 = 1'b1;
         @(posedge clk);
         #1;
      end
      check_val("w4_done", 32'(seen4), 32'd1);
      check_val("w4_adds", 32'(adds), 32'd15);
      check_val("w4_clr", 32'(subs), 32'd1);
      check_val("w4_other", 32'(others), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/ucode_mul_sequencer.md
# ucode_mul_sequencer

- Parametrised microcode expander that sits between ID and the pipeline instruction mux. It turns one decoded multiply-class macro-op (MUL, MAC, MSU by immediate) into a stream of ADD/SUB micro-instructions.
- Operands are latched at start, and both sides use valid/ready handshakes, so downstream stalls are tolerated.
- Register aliasing (dest == source) is handled through a scratch register.
- `busy` stalls IF while a sequence is in flight.

## Interface
Parameters:
- IMM_W, 16, immediate/counter width (≥2)
- SCRATCH_REG, 4'd15, register clobbered by alias handling
- ADD_OPC, 7'b0110001, ADD opcode
- SUB_OPC, 7'b0110010, SUB opcode
- NOP_WORD, {5'b11001,27'b0}, idle output word

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start_valid  in  1  macro-op offered by ID
- start_ready  out  1  high only in IDLE
- start_mode  in  2  00 MUL (rd=rs*imm), 01 MAC (rd+=rs*imm), 10 MSU (rd-=rs*imm), 11 illegal
- dest_reg  in  4  rd
- source_reg  in  4  rs
- immediate  in  IMM_W  multiplier, unsigned
- out_valid  out  1  output_instruction valid
- out_ready  in  1  pipeline accepts the instruction
- output_instruction  out  32  {opc[6:0], rd[3:0], rs1[3:0], rs2[3:0], 13'b0}; NOP_WORD when out_valid=0
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, sequence complete
- err  out  1  one-cycle pulse coincident with done, start rejected

## Operation
- Accept: start_valid && start_ready. On accept, latch mode, rd, rs and imm, and load cnt=imm. Unaccepted inputs are ignored.
- States: IDLE, ACLR, ACPY, CLR, LOOP, DONE. Encodings are free.
- Effective source es = rs, or SCRATCH_REG when the alias path is taken.
- Alias path (UCODE_ALIAS_EN only) is taken when rd==rs and imm≠0:
  - ACLR emits SUB SC,SC,SC.
  - ACPY emits ADD SC,SC,rs.
- CLR (MUL only) emits SUB rd,rd,rd.
- LOOP emits, imm times:
  - ADD rd,rd,es for MUL and MAC.
  - SUB rd,rd,es for MSU.
- Sequences by mode:
  - MUL imm=0: CLR only.
  - MUL imm≥1: [ACLR, ACPY], CLR, LOOP×imm.
  - MAC/MSU imm=0: no instructions; go straight to DONE.
  - MAC/MSU imm≥1: [ACLR, ACPY], LOOP×imm.
- Illegal requests go straight to DONE with err=1 and emit nothing. A request is illegal when:
  - mode 11, or
  - rd==rs==SCRATCH_REG with UCODE_ALIAS_EN defined.
- A state advances only on the out_valid && out_ready handshake. Without the handshake, output_instruction and the state hold.
- LOOP: cnt decrements on each handshake. The handshake taken while cnt==1 exits to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic: cnt is IMM_W bits. imm=2^IMM_W−1 emits exactly that many LOOP instructions with no wrap.

## Timing
- Reset (rst=0 at a clock edge) forces IDLE, regardless of current state and including mid-sequence. Output values after reset:
  - out_valid=0
  - busy=0
  - done=0
  - err=0
  - output_instruction=NOP_WORD
  - start_ready=1 from the first cycle after reset is released
- A start accepted in cycle T gives out_valid=1 in T+1, or DONE in T+1 for empty and illegal sequences.
- With out_ready held at 1, one instruction is emitted per cycle.
- Total busy cycles = instruction count + 1 (DONE), plus any out_ready stall cycles.
- The first start after DONE can be accepted in the cycle after done, since start_ready is 0 during DONE.
- out_valid is never dropped before its handshake.
- out_ready is ignored while out_valid=0.
- Changes on ID inputs during busy have no effect.

## Configuration
- UCODE_ALIAS_EN
  - Defined: ACLR/ACPY states and the scratch-register rules are present.
  - Undefined: those states are removed and rd==rs is emitted unmodified (CLR destroys the source), and the rd==rs==SCRATCH_REG err case does not exist.

## Test plan
- MUL rd=1, rs=0, imm=3, out_ready=1 → SUB 1,1,1; ADD 1,1,0 ×3 on consecutive cycles. done is in T+5 and busy is high T+1..T+5.
- MUL imm=0 → single SUB rd,rd,rd then done. MAC imm=0 → done in T+1 with no out_valid. Mode 11 → done and err in T+1.
- MSU rd=2, rs=3, imm=2 with out_ready low for 3 cycles on the first instruction → instruction held stable, then SUB 2,2,3 ×2, done.
- UCODE_ALIAS_EN defined, MUL rd=rs=5, imm=2 → SUB 15,15,15; ADD 15,15,5; SUB 5,5,5; ADD 5,5,15 ×2. The same request with rd=rs=15 → err.
- Reset pulled low mid-LOOP in MAC imm=100 → next cycle IDLE with out_valid=0, busy=0, start_ready=1. The next MUL imm=1 executes cleanly.
- IMM_W=4, MUL imm=15 → exactly 15 ADDs, no wrap.
